// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan controller.
package seg7_pkg;

    // Message buffer depth (characters); the scroll pointer wraps at this size.
    localparam int MSG_DEPTH = 16;

    // count1 values at which each anode is strobed; every other value is a
    // blanking gap that keeps ghosting off the neighbouring digit.
    localparam logic [3:0] CNT_AN3 = 4'b1110;
    localparam logic [3:0] CNT_AN2 = 4'b1010;
    localparam logic [3:0] CNT_AN1 = 4'b0110;
    localparam logic [3:0] CNT_AN0 = 4'b0010;

    // Character code handed to the segment decoder.
    typedef logic [3:0] char_t;

endpackage

// File: rtl/seg7_prescaler.sv
// Step-strobe generator: one-cycle step pulse every PRESCALE clk cycles.
module seg7_prescaler #(
    parameter logic [15:0] PRESCALE = 16'd50000
) (
    input  logic clk,
    input  logic reset,
    output logic step
);

    logic [15:0] cnt;

    assign step = (cnt == PRESCALE - 16'd1);

    // free-running 0..PRESCALE-1 counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     cnt <= '0;
        else if (step) cnt <= '0;
        else           cnt <= cnt + 16'd1;
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scan sequencer for the 4-digit 7-segment display with a 16-char message.
// Build option SEG7_SCROLL_EN: when defined, a 4-char window scrolls across
// the message every SCROLL_FRAMES frames; when undefined the window is fixed
// on msg[0..3], wr_ready is constant 1 and SCROLL_FRAMES does not exist.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter logic [15:0] PRESCALE = 16'd50000
`ifdef SEG7_SCROLL_EN
    , parameter logic [7:0] SCROLL_FRAMES = 8'd16
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [3:0] wr_addr,
    input  char_t      wr_data,
    output logic [3:0] count1,
    output logic       an3,
    output logic       an2,
    output logic       an1,
    output logic       an0,
    output char_t      digit_char,
    output logic       frame_tick
);

    logic                   step;
    logic [3:0]             cnt_nxt;
    logic [3:0]             an_nxt;
    logic [3:0]             an_q;
    logic [3:0]             ptr;
    logic [3:0]             rd_idx;
    logic [1:0]             off;
    logic                   lit;
    char_t [MSG_DEPTH-1:0]  msg;

    seg7_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk   (clk),
        .reset (reset),
        .step  (step)
    );

    assign cnt_nxt = count1 - 4'd1;   // natural 4-bit wrap 0000 -> 1111
    assign {an3, an2, an1, an0} = an_q;

    // decode the strobe for the value count1 is about to take; off is the
    // window position (0 = leftmost, shown on an3)
    always_comb begin
        an_nxt = 4'b1111;
        off    = 2'd0;
        lit    = 1'b0;
        case (cnt_nxt)
            CNT_AN3: begin an_nxt = 4'b0111; off = 2'd0; lit = 1'b1; end
            CNT_AN2: begin an_nxt = 4'b1011; off = 2'd1; lit = 1'b1; end
            CNT_AN1: begin an_nxt = 4'b1101; off = 2'd2; lit = 1'b1; end
            CNT_AN0: begin an_nxt = 4'b1110; off = 2'd3; lit = 1'b1; end
            default: ;
        endcase
    end

    assign rd_idx = ptr + {2'b00, off};

    // scan counter, anodes and character all move together on a step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count1     <= 4'b1111;
            an_q       <= 4'b1111;
            digit_char <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= step && (count1 == 4'b0000);
            if (step) begin
                count1 <= cnt_nxt;
                an_q   <= an_nxt;
                if (lit) digit_char <= msg[rd_idx];
            end
        end
    end

    // message buffer write port; contents are cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    msg <= '0;
        else if (wr_valid && wr_ready) msg[wr_addr] <= wr_data;
    end

`ifdef SEG7_SCROLL_EN
    logic [7:0] fcnt;
    logic       scroll;

    // the scroll step is the frame_tick cycle that completes SCROLL_FRAMES
    assign scroll   = frame_tick && (fcnt == SCROLL_FRAMES - 8'd1);
    assign wr_ready = ~scroll;

    // frame counter and window pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt <= '0;
            ptr  <= '0;
        end else if (frame_tick) begin
            if (scroll) begin
                fcnt <= '0;
                ptr  <= ptr + 4'd1;
            end else begin
                fcnt <= fcnt + 8'd1;
            end
        end
    end
`else
    assign ptr      = '0;
    assign wr_ready = 1'b1;
`endif

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl, PRESCALE=4 (and SCROLL_FRAMES=2 when
// SEG7_SCROLL_EN is defined).
module tb_seg7_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_valid = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       wr_ready, an3, an2, an1, an0, frame_tick;
    logic [3:0] count1, digit_char;
    logic [3:0] an;
    logic [3:0] mem [16];
    int         ticks = 0;
    int         n_pass = 0;
    int         n_total = 0;

    assign an = {an3, an2, an1, an0};

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .PRESCALE(16'd4)
`ifdef SEG7_SCROLL_EN
        , .SCROLL_FRAMES(8'd2)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .count1     (count1),
        .an3        (an3),
        .an2        (an2),
        .an1        (an1),
        .an0        (an0),
        .digit_char (digit_char),
        .frame_tick (frame_tick)
    );

    // completed frames since reset; drives the window-pointer model
    always @(posedge clk or posedge reset) begin
        if (reset)           ticks <= 0;
        else if (frame_tick) ticks <= ticks + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [3:0] an_exp(input logic [3:0] c);
        case (c)
            4'b1110: return 4'b0111;
            4'b1010: return 4'b1011;
            4'b0110: return 4'b1101;
            4'b0010: return 4'b1110;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [3:0] ptr_m();
`ifdef SEG7_SCROLL_EN
        return 4'(ticks / 2);
`else
        return 4'd0;
`endif
    endfunction

    function automatic logic [1:0] off_of(input logic [3:0] a);
        case (a)
            4'b0111: return 2'd0;
            4'b1011: return 2'd1;
            4'b1101: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 4'd0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write_msg(input logic [3:0] a, input logic [3:0] d);
        bit done;
        done = 1'b0;
        wr_addr = a; wr_data = d; wr_valid = 1'b1;
        for (int i = 0; i < 8 && !done; i++) begin
            done = (wr_ready === 1'b1);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        if (done) mem[a] = d;
        n_total++;
        if (!done) $display("FAIL write_accept slot=%0d: wr_ready stayed 0 for 8 cycles, need 1", a);
        else n_pass++;
    endtask

    task automatic wait_tick();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = (frame_tick === 1'b1);
        end
        n_total++;
        if (!ok) $display("FAIL tick_timeout: no frame_tick in 100 cycles, need one");
        else n_pass++;
    endtask

    task automatic wait_an(input logic [3:0] pat);
        bit ok;
        ok = (an === pat);
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            ok = (an === pat);
        end
        n_total++;
        if (!ok) $display("FAIL anode_timeout: an=%b never reached %b in 80 cycles", an, pat);
        else n_pass++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        clear_mem();
        #1;
        n_total++; if (count1 !== 4'b1111) $display("FAIL rst_count1 got=%b need=1111", count1); else n_pass++;
        n_total++; if (an !== 4'b1111) $display("FAIL rst_anodes got=%b need=1111", an); else n_pass++;
        n_total++; if (digit_char !== 4'd0) $display("FAIL rst_digit got=%h need=0", digit_char); else n_pass++;
        n_total++; if (frame_tick !== 1'b0) $display("FAIL rst_tick got=%b need=0", frame_tick); else n_pass++;
        n_total++; if (wr_ready !== 1'b1) $display("FAIL rst_ready got=%b need=1", wr_ready); else n_pass++;
        release_reset();
    endtask

    // count1 steps every 4 clks from 1111; one frame is 64 clks
    task automatic test_scan();
        logic [3:0] e;
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            e = 4'd15 - 4'(n / 4);
            n_total++; if (count1 !== e) $display("FAIL scan_count n=%0d got=%b need=%b", n, count1, e); else n_pass++;
            n_total++; if (an !== an_exp(e)) $display("FAIL scan_anode n=%0d got=%b need=%b", n, an, an_exp(e)); else n_pass++;
            n_total++; if (frame_tick !== (n == 64)) $display("FAIL scan_tick n=%0d got=%b need=%b", n, frame_tick, n == 64); else n_pass++;
        end
    endtask

    task automatic test_message();
        int lit;
        int last;
        logic [3:0] e;
        lit = 0; last = -1;
        for (int i = 0; i < 4; i++) write_msg(4'(i), 4'(i + 1));
        wait_tick();
        for (int m = 0; m < 64; m++) begin
            @(negedge clk);
            if (an !== 4'b1111) begin
                e = mem[4'(ptr_m() + {2'b00, off_of(an)})];
                lit++; last = int'(e);
                n_total++; if (digit_char !== e) $display("FAIL msg_digit an=%b got=%h need=%h", an, digit_char, e); else n_pass++;
            end else if (last >= 0) begin
                n_total++; if (digit_char !== 4'(last)) $display("FAIL msg_hold got=%h need=%h", digit_char, 4'(last)); else n_pass++;
            end
        end
        n_total++; if (lit != 16) $display("FAIL msg_lit_cycles got=%0d need=16", lit); else n_pass++;
    endtask

    // a write to the lit slot shows only at that digit's next strobe
    task automatic test_live_write();
        logic [3:0] slot, old;
        wait_an(4'b0111);
        slot = ptr_m();
        old = mem[slot];
        write_msg(slot, 4'hA);
        n_total++; if (an !== 4'b0111) $display("FAIL live_still_lit got=%b need=0111", an); else n_pass++;
        n_total++; if (digit_char !== old) $display("FAIL live_old got=%h need=%h", digit_char, old); else n_pass++;
        wait_an(4'b1011);
        wait_an(4'b0111);
        n_total++;
        if (digit_char !== mem[ptr_m()]) $display("FAIL live_new got=%h need=%h", digit_char, mem[ptr_m()]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lit;
        bit ok;
        lit = 0;
        ok = (count1 === 4'b0110);
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            ok = (count1 === 4'b0110);
        end
        n_total++; if (an !== 4'b1101) $display("FAIL mid_an1_lit got=%b need=1101", an); else n_pass++;
        #2 reset = 1'b1;
        clear_mem();
        #1;
        n_total++; if (an !== 4'b1111) $display("FAIL mid_anodes got=%b need=1111", an); else n_pass++;
        n_total++; if (count1 !== 4'b1111) $display("FAIL mid_count1 got=%b need=1111", count1); else n_pass++;
        n_total++; if (digit_char !== 4'd0) $display("FAIL mid_digit got=%h need=0", digit_char); else n_pass++;
        release_reset();
        for (int m = 0; m < 64; m++) begin
            @(negedge clk);
            if (an !== 4'b1111) begin
                lit++;
                n_total++; if (digit_char !== 4'd0) $display("FAIL mid_cleared an=%b got=%h need=0", an, digit_char); else n_pass++;
            end
        end
        n_total++; if (lit != 16) $display("FAIL mid_lit_cycles got=%0d need=16", lit); else n_pass++;
    endtask

`ifdef SEG7_SCROLL_EN
    task automatic wait_ticks(input int target);
        bit ok;
        ok = (ticks >= target);
        for (int i = 0; i < 2600 && !ok; i++) begin
            @(negedge clk);
            ok = (ticks >= target);
        end
        n_total++; if (!ok) $display("FAIL ticks_timeout got=%0d need=%0d", ticks, target); else n_pass++;
    endtask

    task automatic test_scroll();
        @(negedge clk);
        #2 reset = 1'b1;
        clear_mem();
        release_reset();
        for (int i = 0; i < 16; i++) write_msg(4'(i), 4'(i));
        wait_ticks(2);
        wait_an(4'b0111);
        n_total++; if (digit_char !== 4'd1) $display("FAIL scroll1_an3 got=%h need=1", digit_char); else n_pass++;
        wait_an(4'b1011);
        n_total++; if (digit_char !== 4'd2) $display("FAIL scroll1_an2 got=%h need=2", digit_char); else n_pass++;
        wait_an(4'b1101);
        n_total++; if (digit_char !== 4'd3) $display("FAIL scroll1_an1 got=%h need=3", digit_char); else n_pass++;
        wait_an(4'b1110);
        n_total++; if (digit_char !== 4'd4) $display("FAIL scroll1_an0 got=%h need=4", digit_char); else n_pass++;
        wait_ticks(32);
        wait_an(4'b0111);
        n_total++; if (digit_char !== 4'd0) $display("FAIL scroll_wrap_an3 got=%h need=0", digit_char); else n_pass++;
        wait_an(4'b1110);
        n_total++; if (digit_char !== 4'd3) $display("FAIL scroll_wrap_an0 got=%h need=3", digit_char); else n_pass++;
    endtask

    // hold a write across the scroll cycle: refused there, taken next cycle
    task automatic test_ready();
        logic prev;
        bit ok;
        prev = wr_ready;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            prev = wr_ready;
            @(negedge clk);
            ok = (frame_tick === 1'b1) && (ticks % 2 == 1);
        end
        n_total++; if (!ok) $display("FAIL ready_find_scroll: no scroll frame_tick in 200 cycles"); else n_pass++;
        n_total++; if (prev !== 1'b1) $display("FAIL ready_before got=%b need=1", prev); else n_pass++;
        n_total++; if (wr_ready !== 1'b0) $display("FAIL ready_scroll got=%b need=0", wr_ready); else n_pass++;
        wr_addr = 4'd1; wr_data = 4'hF; wr_valid = 1'b1;
        @(negedge clk);
        n_total++; if (wr_ready !== 1'b1) $display("FAIL ready_after got=%b need=1", wr_ready); else n_pass++;
        @(negedge clk);
        wr_valid = 1'b0;
        mem[1] = 4'hF;
        wait_an(4'b0111);
        n_total++; if (digit_char !== 4'hF) $display("FAIL ready_commit got=%h need=f", digit_char); else n_pass++;
    endtask
`else
    // fixed window: 40 frames keep showing 9,8,7,6 and wr_ready never drops
    task automatic test_static();
        int lit;
        logic [3:0] e;
        lit = 0;
        write_msg(4'd0, 4'd9);
        write_msg(4'd1, 4'd8);
        write_msg(4'd2, 4'd7);
        write_msg(4'd3, 4'd6);
        write_msg(4'd4, 4'd5);
        wait_tick();
        for (int m = 0; m < 40 * 64; m++) begin
            @(negedge clk);
            n_total++; if (wr_ready !== 1'b1) $display("FAIL static_ready m=%0d got=%b need=1", m, wr_ready); else n_pass++;
            if (an !== 4'b1111) begin
                case (an)
                    4'b0111: e = 4'd9;
                    4'b1011: e = 4'd8;
                    4'b1101: e = 4'd7;
                    default: e = 4'd6;
                endcase
                lit++;
                n_total++; if (digit_char !== e) $display("FAIL static_digit m=%0d an=%b got=%h need=%h", m, an, digit_char, e); else n_pass++;
            end
        end
        n_total++; if (lit != 640) $display("FAIL static_lit_cycles got=%0d need=640", lit); else n_pass++;
    endtask
`endif

    initial begin
        clear_mem();
        test_reset();
        test_scan();
        test_message();
        test_live_write();
        test_reset_mid();
`ifdef SEG7_SCROLL_EN
        test_scroll();
        test_ready();
`else
        test_static();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Sequencer for the 4-digit 7-segment display on the lab board.
- Generates the 4-bit down-counter that time-multiplexes the anodes, decodes the anode strobes, and selects which 4-bit character feeds the segment decoder.
- Holds a 16-entry character message with a write port and scrolls a 4-character window across it.
- Sits between the top level (switch/button logic, message writer) and the segment decoder / board pins.

Parameters:
- PRESCALE, 16'd50000, clk cycles per count1 step (min 2; sims use 4).
- SCROLL_FRAMES, 8'd16, full scan frames per scroll step (min 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  message write request.
- wr_ready  out  1  controller can accept a write this cycle.
- wr_addr  in  4  message slot 0..15.
- wr_data  in  4  character code for that slot.
- count1  out  4  scan down-counter value.
- an3, an2, an1, an0  out  1 each  anodes, active low.
- digit_char  out  4  character for the currently lit digit, to the segment decoder.
- frame_tick  out  1  one-cycle pulse per completed scan frame.

Behaviour:
- Reset is asynchronous, active-high. All registers take reset values immediately on assertion, regardless of clk.
- Reset values:
  - count1=4'b1111, an3..an0=1 (all dark), digit_char=0.
  - frame_tick=0, wr_ready=1.
  - Prescaler=0, scroll pointer ptr=0, frame counter=0, message RAM all 0.
- Prescaler: counts 0..PRESCALE-1. The step strobe fires on the cycle it equals PRESCALE-1, then it returns to 0.
- On step: count1 <= count1-1, wrapping 4'b0000 -> 4'b1111.
- Anodes are registered and updated on the same edge as count1; they always match the new count1 value:
  - 4'b1110 -> an3=0.
  - 4'b1010 -> an2=0.
  - 4'b0110 -> an1=0.
  - 4'b0010 -> an0=0.
  - All other values -> all anodes 1 (blanking gap). At most one anode is ever 0.
- digit_char is registered on the same edge. With k the lit digit (3..0), digit_char = msg[(ptr + 3 - k) mod 16]; an3 shows the leftmost character. In blank states digit_char holds its previous value.
- frame_tick=1 for exactly one cycle, the cycle after count1 wraps 4'b0000 -> 4'b1111.
- Frame counter: increments on each frame_tick, 0..SCROLL_FRAMES-1. When it wraps, ptr <= ptr+1 mod 16 (scroll step, one cycle).
- Write handshake:
  - A write occurs when wr_valid & wr_ready are both high at a clk edge: msg[wr_addr] <= wr_data.
  - wr_ready is deasserted (0) for exactly the one cycle in which the scroll step occurs; the writer holds wr_valid/addr/data until accepted.
  - A write to a slot currently displayed takes effect at that digit's next strobe.
- Back-to-back writes are accepted every cycle except the scroll cycle.
- Reset mid-frame: outputs go to reset values at once. The message contents are lost (RAM cleared).

Optional Feature:
- Macro SEG7_SCROLL_EN.
- Defined: scrolling as above.
- Undefined: ptr is fixed at 0, the frame counter is removed, wr_ready is tied to 1, and the display shows msg[0..3] statically. frame_tick is still generated.

Decomposition:
- Shared package seg7_pkg:
  - Anode strobe constants CNT_AN3=4'b1110, CNT_AN2=4'b1010, CNT_AN1=4'b0110, CNT_AN0=4'b0010.
  - MSG_DEPTH=16.
  - Character-code typedef (4-bit).
- One natural sub-module: seg7_prescaler (the parameterised step-strobe generator), reusable by other lab designs.

Test Plan:
- Reset, then PRESCALE=4 -> count1 = 1111, 1110, 1101 … stepping every 4 clks. an3=0 only while count1=1110; all anodes 1 in the 12 gap states.
- Write msg[0..3] = 1,2,3,4, then run one frame -> digit_char = 1 with an3, 2 with an2, 3 with an1, 4 with an0.
- Set SCROLL_FRAMES=2, msg[i]=i, run 2 frames -> ptr=1 and an3 shows 1. After 32 frames ptr wraps to 0 and an0 shows 3.
- Hold wr_valid high across the scroll-step cycle -> wr_ready=0 for exactly 1 cycle, and the write commits on the following cycle.
- Assert reset asynchronously mid-frame with count1=0110 -> an1 returns to 1 and count1 = 1111 before the next clk edge, and msg reads 0.
- Build without SEG7_SCROLL_EN, msg[0..4] = 9,8,7,6,5, run 40 frames -> the display stays 9,8,7,6 and wr_ready is constantly 1.
